// File: rtl/rolha_refill_scheduler.sv
// rtl/rolha_refill_scheduler.sv - cork magazine/reserve owner with sequenced automatic refill
module rolha_refill_scheduler #(
    parameter int MAX_ROLHAS    = 20,
    parameter int ESTOQUE_MAX   = 15,
    parameter int REFILL_LIMIAR = 5,
    parameter int LOTE          = 10,
    parameter int CONTAGEM_INIT = 20,
    parameter int ESTOQUE_INIT  = 15,
    parameter int DISP_CICLOS   = 3
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       dec,
    input  logic       add_manual,
    output logic [4:0] contagem,
    output logic [3:0] estoque,
    output logic       disp_acionado,
    output logic       rolha_disponivel,
    output logic       alarme_rolha,
    output logic       dec_erro,
    output logic       refill_ocupado
);

    localparam int CW = (DISP_CICLOS > 1) ? $clog2(DISP_CICLOS) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(DISP_CICLOS - 1);
    localparam logic [4:0] MAX5  = 5'(MAX_ROLHAS);
    localparam logic [4:0] LIM5  = 5'(REFILL_LIMIAR);
    localparam logic [4:0] LOTE5 = (LOTE > 31) ? 5'd31 : 5'(LOTE);
    localparam logic [4:0] EMAX5 = 5'(ESTOQUE_MAX);

    typedef enum logic [1:0] {OCIOSO, DISPENSA, TRANSFERE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    contagem_q, contagem_d;
    logic [3:0]    estoque_q, estoque_d;
    logic          add_prev_q;
    logic          dec_erro_q, dec_erro_d;

    logic          add_edge;
    logic          dec_ok;
    logic [4:0]    c_prime;
    logic [4:0]    room;
    logic [4:0]    n;
    logic [3:0]    e_base;
    logic [4:0]    e_sum;

    // State register and dispense cycle counter
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q <= OCIOSO;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: refill request from idle, timed dispense, single-cycle transfer
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            OCIOSO: begin
                // registered count only; a dec in this cycle does not delay the request
                if (contagem_q <= LIM5 && estoque_q != 4'd0) begin
                    state_d = DISPENSA;
                    cnt_d   = CNT_LOAD;
                end
            end
            DISPENSA: begin
                if (cnt_q == '0) state_d = TRANSFERE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            TRANSFERE: state_d = OCIOSO;
            default:   state_d = OCIOSO;
        endcase
    end

    // Outputs decoded from the state register so reset drops them immediately
    always_comb begin
        disp_acionado  = (state_q == DISPENSA);
        refill_ocupado = (state_q != OCIOSO);
    end

    // Count arithmetic: sealing decrement, transfer amount, saturating manual add
    always_comb begin
        add_edge   = add_manual & ~add_prev_q;
        dec_ok     = dec & (contagem_q != 5'd0);
        dec_erro_d = dec & (contagem_q == 5'd0);
        c_prime    = contagem_q - {4'd0, dec_ok};
        room       = MAX5 - c_prime;
        n          = LOTE5;
        if (room < n) n = room;
        if ({1'b0, estoque_q} < n) n = {1'b0, estoque_q};
        if (state_q == TRANSFERE) begin
            contagem_d = c_prime + n;
            e_base     = estoque_q - n[3:0];
        end else begin
            contagem_d = c_prime;
            e_base     = estoque_q;
        end
        // manual add lands after the transfer subtraction, then saturates
        e_sum     = {1'b0, e_base} + {4'd0, add_edge};
        estoque_d = (e_sum > EMAX5) ? EMAX5[3:0] : e_sum[3:0];
    end

    // Count registers, add edge sampler and error pulse
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            contagem_q <= 5'(CONTAGEM_INIT);
            estoque_q  <= 4'(ESTOQUE_INIT);
            add_prev_q <= 1'b0;
            dec_erro_q <= 1'b0;
        end else begin
            contagem_q <= contagem_d;
            estoque_q  <= estoque_d;
            add_prev_q <= add_manual;
            dec_erro_q <= dec_erro_d;
        end
    end

    assign contagem         = contagem_q;
    assign estoque          = estoque_q;
    assign dec_erro         = dec_erro_q;
    assign rolha_disponivel = (contagem_q != 5'd0);
    assign alarme_rolha     = (contagem_q == 5'd0) && (estoque_q == 4'd0);

endmodule
